// File: rtl/hilo_pkg.sv
// Shared op encoding and FSM state encoding for the HI/LO register unit.
package hilo_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
  localparam logic [OP_W-1:0] OP_WR_BOTH = 3'd1;
  localparam logic [OP_W-1:0] OP_WR_HI   = 3'd2;
  localparam logic [OP_W-1:0] OP_WR_LO   = 3'd3;
  localparam logic [OP_W-1:0] OP_MADD    = 3'd4;
  localparam logic [OP_W-1:0] OP_MSUB    = 3'd5;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACC_HI = 1'b1
  } state_t;

endpackage

// File: rtl/hilo_addsub.sv
// W-bit add/subtract with carry/borrow in and out; only built when HILO_ACC_EN is defined.
`ifdef HILO_ACC_EN
module hilo_addsub #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [W-1:0] y_c,
  output logic         cout_c
);

  logic [W:0] sum;

  // In subtract mode cin is a borrow-in and the top bit is the borrow-out.
  always_comb begin
    if (sub) sum = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
    else     sum = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  end

  assign y_c    = sum[W-1:0];
  assign cout_c = sum[W];

endmodule
`endif

// File: rtl/hilo_unit.sv
// HI/LO register pair with direct writes and optional two-cycle multiply-accumulate style add/sub.
// Macro HILO_ACC_EN enables MADD/MSUB; without it those op codes are NOPs and busy is tied low.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    hi_in,
  input  logic [W-1:0]    lo_in,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    hilo_hi,
  output logic [W-1:0]    hilo_lo
);

`ifdef HILO_ACC_EN

  state_t         state;
  logic           carry;
  logic           sub_q;
  logic [W-1:0]   hi_in_reg;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_y;
  logic           add_sub;
  logic           add_cin;
  logic           add_cout;

  // One adder serves both halves: LO in IDLE, HI (with saved carry) in ACC_HI.
  always_comb begin
    add_a   = hilo_lo;
    add_b   = lo_in;
    add_sub = (op == OP_MSUB);
    add_cin = 1'b0;
    if (state == S_ACC_HI) begin
      add_a   = hilo_hi;
      add_b   = hi_in_reg;
      add_sub = sub_q;
      add_cin = carry;
    end
  end

  hilo_addsub #(.W(W)) u_addsub (
    .a      (add_a),
    .b      (add_b),
    .sub    (add_sub),
    .cin    (add_cin),
    .y_c    (add_y),
    .cout_c (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry     <= 1'b0;
      sub_q     <= 1'b0;
      hi_in_reg <= '0;
      hilo_hi   <= '0;
      hilo_lo   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            case (op)
              OP_WR_BOTH: begin
                hilo_hi <= hi_in;
                hilo_lo <= lo_in;
                done    <= 1'b1;
              end
              OP_WR_HI: begin
                hilo_hi <= hi_in;
                done    <= 1'b1;
              end
              OP_WR_LO: begin
                hilo_lo <= lo_in;
                done    <= 1'b1;
              end
              OP_MADD, OP_MSUB: begin
                hilo_lo   <= add_y;
                carry     <= add_cout;
                sub_q     <= (op == OP_MSUB);
                hi_in_reg <= hi_in;
                state     <= S_ACC_HI;
                busy      <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_ACC_HI: begin
          hilo_hi <= add_y;
          state   <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`else

  assign busy = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      done    <= 1'b0;
      hilo_hi <= '0;
      hilo_lo <= '0;
    end else begin
      done <= 1'b0;
      if (in_valid) begin
        case (op)
          OP_WR_BOTH: begin
            hilo_hi <= hi_in;
            hilo_lo <= lo_in;
            done    <= 1'b1;
          end
          OP_WR_HI: begin
            hilo_hi <= hi_in;
            done    <= 1'b1;
          end
          OP_WR_LO: begin
            hilo_lo <= lo_in;
            done    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit (W=32); covers both HILO_ACC_EN builds.
module tb_hilo_unit;

`ifdef HILO_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  op;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        busy;
  logic        done;
  logic [31:0] hilo_hi;
  logic [31:0] hilo_lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state as a single 64-bit value.
  logic [63:0] m_acc;

  hilo_unit #(.W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .op       (op),
    .hi_in    (hi_in),
    .lo_in    (lo_in),
    .busy     (busy),
    .done     (done),
    .hilo_hi  (hilo_hi),
    .hilo_lo  (hilo_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_next(input logic [63:0] acc, input logic [2:0] o,
                                             input logic [31:0] h, input logic [31:0] l);
    logic [63:0] r;
    r = acc;
    case (o)
      3'd1: r = {h, l};
      3'd2: r[63:32] = h;
      3'd3: r[31:0] = l;
      3'd4: if (ACC) r = acc + {h, l};
      3'd5: if (ACC) r = acc - {h, l};
      default: ;
    endcase
    return r;
  endfunction

  function automatic int expect_done(input logic [2:0] o);
    if (o >= 3'd1 && o <= 3'd3) return 1;
    if (ACC && (o == 3'd4 || o == 3'd5)) return 1;
    return 0;
  endfunction

  task automatic test_reset();
    op = 3'd1; hi_in = $urandom; lo_in = $urandom; in_valid = 1'b1;
    tick();
    rst = 1'b0; op = 3'd1; hi_in = $urandom; lo_in = $urandom;
    tick();
    n_checks++;
    if ({busy, done, hilo_hi, hilo_lo} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hilo_hi, hilo_lo);
    end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    n_checks++;
    if ({busy, done, hilo_hi, hilo_lo} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hilo_hi, hilo_lo);
    end
    m_acc = 64'h0;
  endtask

  task automatic test_writes();
    op = 3'd1; hi_in = 32'h12345678; lo_in = 32'h9ABCDEF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({busy, done, hilo_hi, hilo_lo} !== {2'b01, 32'h12345678, 32'h9ABCDEF0}) begin
      n_fail++;
      $display("FAIL wr_both: got busy=%b done=%b hi=%h lo=%h, want 0 1 12345678 9abcdef0", busy, done, hilo_hi, hilo_lo);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_both_done_pulse: got done=%b, want 0", done);
    end
    op = 3'd2; hi_in = 32'hAAAA0000; lo_in = 32'h55555555; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({done, hilo_hi, hilo_lo} !== {1'b1, 32'hAAAA0000, 32'h9ABCDEF0}) begin
      n_fail++;
      $display("FAIL wr_hi: got done=%b hi=%h lo=%h, want 1 aaaa0000 9abcdef0", done, hilo_hi, hilo_lo);
    end
    op = 3'd3; hi_in = 32'h11111111; lo_in = 32'h0000BEEF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({done, hilo_hi, hilo_lo} !== {1'b1, 32'hAAAA0000, 32'h0000BEEF}) begin
      n_fail++;
      $display("FAIL wr_lo: got done=%b hi=%h lo=%h, want 1 aaaa0000 0000beef", done, hilo_hi, hilo_lo);
    end
    tick();
    m_acc = {32'hAAAA0000, 32'h0000BEEF};
  endtask

  task automatic test_nop();
    logic [2:0] ops [5];
    logic [31:0] h0, l0;
    ops[0] = 3'd0; ops[1] = 3'd6; ops[2] = 3'd7; ops[3] = 3'd4; ops[4] = 3'd5;
    for (int i = 0; i < (ACC ? 3 : 5); i++) begin
      h0 = hilo_hi; l0 = hilo_lo;
      op = ops[i]; hi_in = $urandom; lo_in = $urandom; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if ({busy, done, hilo_hi, hilo_lo} !== {2'b00, h0, l0}) begin
        n_fail++;
        $display("FAIL nop_op%0d: got busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h", ops[i], busy, done, hilo_hi, hilo_lo, h0, l0);
      end
      tick();
    end
  endtask

  task automatic load(input logic [31:0] h, input logic [31:0] l);
    op = 3'd1; hi_in = h; lo_in = l; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    m_acc = {h, l};
  endtask

  task automatic test_madd();
    load(32'h0, 32'hFFFFFFFF);
    op = 3'd4; hi_in = 32'h0; lo_in = 32'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; hi_in = 32'hDEADBEEF;
    n_checks++;
    if ({busy, done, hilo_lo} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL madd_edge1: got busy=%b done=%b lo=%h, want 1 0 00000000", busy, done, hilo_lo);
    end
    tick();
    n_checks++;
    if ({busy, done, hilo_hi, hilo_lo} !== {2'b01, 32'h1, 32'h0}) begin
      n_fail++;
      $display("FAIL madd_edge2: got busy=%b done=%b hi=%h lo=%h, want 0 1 00000001 00000000", busy, done, hilo_hi, hilo_lo);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL madd_done_pulse: got done=%b, want 0", done);
    end
  endtask

  task automatic test_msub();
    load(32'h1, 32'h0);
    op = 3'd5; hi_in = 32'h0; lo_in = 32'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({busy, hilo_hi, hilo_lo} !== {1'b1, 32'h1, 32'hFFFFFFFF}) begin
      n_fail++;
      $display("FAIL msub_edge1: got busy=%b hi=%h lo=%h, want 1 00000001 ffffffff", busy, hilo_hi, hilo_lo);
    end
    tick();
    n_checks++;
    if ({busy, done, hilo_hi, hilo_lo} !== {2'b01, 32'h0, 32'hFFFFFFFF}) begin
      n_fail++;
      $display("FAIL msub_edge2: got busy=%b done=%b hi=%h lo=%h, want 0 1 00000000 ffffffff", busy, done, hilo_hi, hilo_lo);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_acc;
    load($urandom, $urandom);
    op = 3'd4; hi_in = $urandom; lo_in = $urandom; in_valid = 1'b1;
    exp_acc = m_acc + {hi_in, lo_in};
    tick();
    op = 3'd3; hi_in = $urandom; lo_in = 32'h5;
    tick();
    n_checks++;
    if ({busy, done, hilo_hi, hilo_lo} !== {2'b01, exp_acc}) begin
      n_fail++;
      $display("FAIL held_req_ignored: got busy=%b done=%b hi=%h lo=%h, want 0 1 %h", busy, done, hilo_hi, hilo_lo, exp_acc);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({done, hilo_hi, hilo_lo} !== {1'b1, exp_acc[63:32], 32'h5}) begin
      n_fail++;
      $display("FAIL held_req_accepted: got done=%b hi=%h lo=%h, want 1 %h 00000005", done, hilo_hi, hilo_lo, exp_acc[63:32]);
    end
    tick();
    m_acc = {exp_acc[63:32], 32'h5};
  endtask

  task automatic test_reset_acc();
    load($urandom | 32'h1, $urandom | 32'h1);
    op = 3'd4; hi_in = $urandom | 32'h1; lo_in = $urandom; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++;
    if ({busy, done, hilo_hi, hilo_lo} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_in_acc: got busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hilo_hi, hilo_lo);
    end
    tick();
    n_checks++;
    if ({busy, done, hilo_hi, hilo_lo} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_in_acc_after: got busy=%b done=%b hi=%h lo=%h, want all zero", busy, done, hilo_hi, hilo_lo);
    end
    m_acc = 64'h0;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] h, l;
    int          dones;
    logic        busy1;
    for (int t = 0; t < 150; t++) begin
      o = 3'($urandom_range(0, 7));
      h = (t % 5 == 0) ? 32'hFFFFFFFF : $urandom;
      l = (t % 3 == 0) ? 32'hFFFFFFFF : $urandom;
      op = o; hi_in = h; lo_in = l; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; op = 3'($urandom); hi_in = $urandom; lo_in = $urandom;
      busy1 = busy;
      dones = int'(done);
      for (int i = 0; i < 3; i++) begin
        tick();
        dones += int'(done);
      end
      m_acc = model_next(m_acc, o, h, l);
      n_checks++;
      if ({busy, hilo_hi, hilo_lo} !== {1'b0, m_acc} || dones != expect_done(o)
          || busy1 !== (ACC && (o == 3'd4 || o == 3'd5))) begin
        n_fail++;
        $display("FAIL random_t%0d_op%0d: got busy=%b/%b dones=%0d hi=%h lo=%h, want busy=%b/0 dones=%0d val=%h",
                 t, o, busy1, busy, dones, hilo_hi, hilo_lo, (ACC && (o == 3'd4 || o == 3'd5)),
                 expect_done(o), m_acc);
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; op = 3'd0; hi_in = '0; lo_in = '0;
    m_acc = 64'h0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    test_reset();
    test_writes();
    test_nop();
`ifdef HILO_ACC_EN
    test_madd();
    test_msub();
    test_back_to_back();
    test_reset_acc();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
